// File: rtl/mem2p_rd_stream_pkg.sv
// mem2p_rd_stream_pkg: shared state encoding and address-width helper for the RAM read streamers.
package mem2p_rd_stream_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/mem2p_skid2.sv
// mem2p_skid2: 2-entry FIFO of {last, data} with synchronous flush.
module mem2p_skid2 #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W:0]   din,
  output logic [W:0]   dout,
  output logic [1:0]   cnt
);
  logic [W:0] mem [2];
  logic       wp, rp;
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
endmodule

// File: rtl/mem2p_rd_stream.sv
// mem2p_rd_stream: reads len words from a 1-cycle-latency RAM and streams them out with valid/ready/last.
module mem2p_rd_stream
  import mem2p_rd_stream_pkg::*;
#(
  parameter  int DEPTH = 2048,
  parameter  int WIDTH = 24,
  localparam int A     = addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [A-1:0]     base_addr,
  input  logic [A:0]       len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [A-1:0]     mem_addrr,
  output logic             mem_mer,
  input  logic [WIDTH-1:0] mem_dout,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready
);
  state_t       state;
  logic [A-1:0] addr;
  logic [A:0]   rem;
  logic         inflight, inflight_last, pop, issue, rem_one;
  logic [1:0]   cnt;
  logic [2:0]   occ;
  logic [WIDTH:0] head;
  // Issue only if the word will still fit once everything already requested has landed.
  always_comb begin
    pop     = m_valid & m_ready;
    occ     = {1'b0, cnt} + {2'b0, inflight} - {2'b0, pop};
    rem_one = rem == (A+1)'(1);
    issue   = (state == RUN) && (rem != '0) && (occ < 3'd2);
  end
  assign busy      = state != IDLE;
  assign m_valid   = cnt != 2'd0;
  assign mem_mer   = issue;
  assign mem_addrr = addr;
  assign {m_last, m_data} = head;
  mem2p_skid2 #(.W(WIDTH)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (inflight),
    .pop   (pop),
    .din   ({inflight_last, mem_dout}),
    .dout  (head),
    .cnt   (cnt)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      addr          <= '0;
      rem           <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
    end else begin
      done          <= 1'b0;
      inflight      <= issue & ~abort;
      inflight_last <= issue & rem_one & ~abort;
      if (abort) state <= IDLE;
      else case (state)
        IDLE: if (start) begin
          if (len != '0) begin
            state <= RUN;
            addr  <= base_addr;
            rem   <= len;
          end else done <= 1'b1;
        end
        RUN: if (issue) begin
          addr <= (addr == A'(DEPTH-1)) ? '0 : addr + A'(1);
          rem  <= rem - (A+1)'(1);
          if (rem_one) state <= DRAIN;
        end
        DRAIN: if (pop && m_last) begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
